hazard_scheduler: RTL and testbench
===================================

# hazard_scheduler

Pipeline hazard scheduler for the five-stage redirect (forwarding) MIPS pipeline. It tracks destination registers of instructions in EX, MEM and WB. From that it produces:
- load-use stalls and EX bubbles;
- taken-branch flushes;
- registered forwarding selects for the EX-stage operand muxes;
- a syscall halt/drain sequence.

It sits beside the decoder and consumes the decoder's ID-stage fields: ra, rb, op-derived flags, dmload.

## Interface
- CNT_W, 16, width of the stall/flush performance counters (saturating)
- clk  in  1  pipeline clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- id_valid  in  1  ID stage holds a real instruction
- id_ra  in  5  first source register of ID instruction
- id_rb  in  5  second source register of ID instruction
- id_use_ra  in  1  ID instruction reads id_ra
- id_use_rb  in  1  ID instruction reads id_rb
- id_wr_en  in  1  ID instruction writes a register
- id_wr_reg  in  5  destination register of ID instruction
- id_load  in  1  ID instruction is a load (decoder dmload)
- id_halt  in  1  ID instruction is syscall-halt (op 0, funct 0x0c)
- ex_br_taken  in  1  branch/jump in EX resolved taken this cycle
- stall  out  1  hold PC and IF/ID register
- bubble  out  1  load NOP into ID/EX register
- flush  out  1  kill IF/ID contents
- fwd_a  out  2  EX operand A select: 00 regfile, 01 EX/MEM ALU result, 10 MEM/WB result
- fwd_b  out  2  same encoding for operand B
- halted  out  1  pipeline drained after syscall halt
- stall_cnt  out  CNT_W  count of load-use stall cycles
- flush_cnt  out  CNT_W  count of flush cycles

## Operation
- Scoreboard has three entries, EX, MEM and WB. Each entry holds {v, wr, reg[4:0], ld}.
- Every cycle the entries shift: MEM<=EX, WB<=MEM. EX<=ID fields when the ID instruction advances; otherwise EX<=bubble (all fields 0).
- The ID instruction advances when id_valid & ~stall & ~flush & state==RUN.
- A hazard match on an entry requires all of: v & wr & reg!=0 & reg equals the source register, with the matching use bit set.
- Load-use (combinational): state==RUN & ~ex_br_taken & id_valid & ld on an EX entry that matches ra or rb. Then stall=1, bubble=1.
- Flush: ex_br_taken=1 gives flush=1 and bubble=1 with stall=0. Flush overrides load-use and halt in the same cycle.
- Forwarding selects are computed in ID for ra and rb and registered into fwd_a/fwd_b when the instruction advances.
  - Priority: a non-load EX match gives 01; else a MEM match gives 10; else 00.
  - A WB match needs no forwarding: the regfile is write-before-read within a cycle.
  - On a bubble, fwd_a/fwd_b register to 00.
- Halt FSM states are RUN, DRAIN and HALTED.
  - RUN->DRAIN: id_valid & id_halt & ~stall & ~flush. The halt instruction itself does not enter EX.
  - DRAIN: stall=1, bubble=1. DRAIN->HALTED when the EX, MEM and WB entries are all v=0.
  - HALTED: stall=1, bubble=1, halted=1. It leaves HALTED only on reset.
  - ex_br_taken in DRAIN is ignored; it is impossible there.
- stall_cnt increments on load-use stall cycles only (not DRAIN/HALTED). flush_cnt increments on flush cycles. Both saturate at all-ones.

## Timing
- Reset values:
  - all entries invalid; state=RUN;
  - fwd_a=fwd_b=00; stall_cnt=flush_cnt=0; halted=0;
  - stall/bubble/flush=0 while id_valid=0 and ex_br_taken=0.
- stall, bubble and flush are combinational from inputs and state, valid in the same cycle.
- fwd_a/fwd_b are registered and valid during the cycle the instruction is in EX. halted is registered.
- Load-use costs exactly 1 stall cycle. On the next cycle the load is in MEM, giving fwd=10.
- Flush costs 1 cycle per ex_br_taken pulse.
- Halt drain: halted rises 3 cycles after entering DRAIN if all stages held instructions, 1 cycle if already empty.
- Reset mid-operation clears everything asynchronously. No partial drain state survives.

## Test plan
- Back-to-back ALU dependency:
  - add r3 (ID wr r3), then next cycle ID reads ra=3 -> stall=0; fwd_a=01 in the EX cycle of the consumer.
  - With one unrelated instruction between -> fwd_a=10.
- Load-use:
  - lw r5 then consumer with rb=5 -> stall=1 and bubble=1 for exactly 1 cycle; fwd_b=10 on the following EX cycle; stall_cnt=1.
- Register 0:
  - producer wr_reg=0, consumer ra=0 -> no stall, fwd_a=00, also for a load producer.
- Flush precedence:
  - ex_br_taken=1 in the same cycle as a load-use match -> flush=1, bubble=1, stall=0; flush_cnt=1, stall_cnt unchanged.
- Halt drain:
  - three ALU ops followed by syscall -> DRAIN; stall held; halted=1 exactly 3 cycles later.
  - Assert rst_n=0 while halted -> halted=0, state RUN, counters 0.
- Counter saturation (CNT_W=4):
  - 20 load-use stalls -> stall_cnt holds 0xF.

Source files
------------

// File: rtl/hazard_scheduler_if.sv
// Decoder/scheduler handshake: ID-stage hazard fields in, stall/flush/forward controls out.
interface hazard_scheduler_if #(
    parameter int unsigned CNT_W = 16
);
    logic             id_valid;
    logic [4:0]       id_ra;
    logic [4:0]       id_rb;
    logic             id_use_ra;
    logic             id_use_rb;
    logic             id_wr_en;
    logic [4:0]       id_wr_reg;
    logic             id_load;
    logic             id_halt;
    logic             ex_br_taken;
    logic             stall;
    logic             bubble;
    logic             flush;
    logic [1:0]       fwd_a;
    logic [1:0]       fwd_b;
    logic             halted;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        output id_valid, id_ra, id_rb, id_use_ra, id_use_rb, id_wr_en, id_wr_reg,
               id_load, id_halt, ex_br_taken,
        input  stall, bubble, flush, fwd_a, fwd_b, halted, stall_cnt, flush_cnt
    );

    modport slave (
        input  id_valid, id_ra, id_rb, id_use_ra, id_use_rb, id_wr_en, id_wr_reg,
               id_load, id_halt, ex_br_taken,
        output stall, bubble, flush, fwd_a, fwd_b, halted, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/hazard_scheduler.sv
// Five-stage MIPS hazard scheduler: EX/MEM/WB destination scoreboard, load-use stall,
// branch flush, registered forwarding selects and syscall halt/drain.
module hazard_scheduler #(
    parameter int unsigned CNT_W = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    hazard_scheduler_if.slave bus
);

    typedef enum logic [1:0] {StRun, StDrain, StHalted} state_e;

    typedef struct packed {
        logic       v;
        logic       wr;
        logic [4:0] rg;
        logic       ld;
    } entry_t;

    localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

    state_e     state_q, state_d;
    entry_t     ex_q, mem_q, wb_q, ex_d;
    logic [1:0] fwd_a_q, fwd_b_q, fwd_a_d, fwd_b_d;
    logic       halted_q;
    logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

    logic ex_hit_a, ex_hit_b, mem_hit_a, mem_hit_b;
    logic load_use, advance, issue;
    logic stall, bubble, flush;

    function automatic logic hit(entry_t e, logic [4:0] src, logic rd);
        return e.v & e.wr & (e.rg != 5'd0) & (e.rg == src) & rd;
    endfunction

    function automatic logic [1:0] fwd_sel(logic ex_hit, logic ex_ld, logic mem_hit);
        if (ex_hit && !ex_ld) begin
            return 2'b01;
        end else if (mem_hit) begin
            return 2'b10;
        end
        return 2'b00;
    endfunction

    always_comb begin
        ex_hit_a  = hit(ex_q,  bus.id_ra, bus.id_use_ra);
        ex_hit_b  = hit(ex_q,  bus.id_rb, bus.id_use_rb);
        mem_hit_a = hit(mem_q, bus.id_ra, bus.id_use_ra);
        mem_hit_b = hit(mem_q, bus.id_rb, bus.id_use_rb);
        load_use  = (state_q == StRun) & ~bus.ex_br_taken & bus.id_valid & ex_q.ld
                  & (ex_hit_a | ex_hit_b);
    end

    // Output decode: flush wins over load-use; drain and halted hold the front end.
    always_comb begin
        stall  = 1'b0;
        bubble = 1'b0;
        flush  = 1'b0;
        case (state_q)
            StRun: begin
                if (bus.ex_br_taken) begin
                    flush  = 1'b1;
                    bubble = 1'b1;
                end else if (load_use) begin
                    stall  = 1'b1;
                    bubble = 1'b1;
                end
            end
            StDrain, StHalted: begin
                stall  = 1'b1;
                bubble = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        advance = bus.id_valid & ~stall & ~flush & (state_q == StRun);
        // The halt instruction itself never enters EX.
        issue   = advance & ~bus.id_halt;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StRun:    if (advance && bus.id_halt) state_d = StDrain;
            StDrain:  if (!ex_q.v && !mem_q.v && !wb_q.v) state_d = StHalted;
            StHalted: state_d = StHalted;
            default:  state_d = StRun;
        endcase
    end

    always_comb begin
        ex_d    = '0;
        fwd_a_d = 2'b00;
        fwd_b_d = 2'b00;
        if (issue) begin
            ex_d    = '{v: 1'b1, wr: bus.id_wr_en, rg: bus.id_wr_reg, ld: bus.id_load};
            fwd_a_d = fwd_sel(ex_hit_a, ex_q.ld, mem_hit_a);
            fwd_b_d = fwd_sel(ex_hit_b, ex_q.ld, mem_hit_b);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StRun;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            halted_q <= (state_d == StHalted);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q    <= '0;
            mem_q   <= '0;
            wb_q    <= '0;
            fwd_a_q <= 2'b00;
            fwd_b_q <= 2'b00;
        end else begin
            ex_q    <= ex_d;
            mem_q   <= ex_q;
            wb_q    <= mem_q;
            fwd_a_q <= fwd_a_d;
            fwd_b_q <= fwd_b_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (load_use && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + CntOne;
            if (flush && (flush_cnt_q != '1))    flush_cnt_q <= flush_cnt_q + CntOne;
        end
    end

    assign bus.stall     = stall;
    assign bus.bubble    = bubble;
    assign bus.flush     = flush;
    assign bus.fwd_a     = fwd_a_q;
    assign bus.fwd_b     = fwd_b_q;
    assign bus.halted    = halted_q;
    assign bus.stall_cnt = stall_cnt_q;
    assign bus.flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_hazard_scheduler.sv
// Directed bench for hazard_scheduler: forwarding, load-use, r0, flush, halt drain, saturation.
module tb_hazard_scheduler;

    localparam int unsigned CNT_W = 4;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    int   n;

    always #5 clk = ~clk;

    hazard_scheduler_if #(.CNT_W(CNT_W)) bus ();

    hazard_scheduler #(.CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic id_idle();
        bus.id_valid  = 1'b0;
        bus.id_ra     = 5'd0;
        bus.id_rb     = 5'd0;
        bus.id_use_ra = 1'b0;
        bus.id_use_rb = 1'b0;
        bus.id_wr_en  = 1'b0;
        bus.id_wr_reg = 5'd0;
        bus.id_load   = 1'b0;
        bus.id_halt   = 1'b0;
    endtask

    task automatic id_op(input logic [4:0] wreg, input logic ld,
                         input logic [4:0] ra, input logic ura,
                         input logic [4:0] rb, input logic urb);
        bus.id_valid  = 1'b1;
        bus.id_ra     = ra;
        bus.id_rb     = rb;
        bus.id_use_ra = ura;
        bus.id_use_rb = urb;
        bus.id_wr_en  = 1'b1;
        bus.id_wr_reg = wreg;
        bus.id_load   = ld;
        bus.id_halt   = 1'b0;
    endtask

    task automatic id_syscall();
        id_idle();
        bus.id_valid = 1'b1;
        bus.id_halt  = 1'b1;
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic cycle();
        @(negedge clk);
        next();
    endtask

    task automatic idle_cycles(input int k);
        id_idle();
        repeat (k) cycle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        bus.ex_br_taken = 1'b0;
        id_idle();
        repeat (2) @(negedge clk);
        check_eq("rst_fwd_a",     32'(bus.fwd_a), 0);
        check_eq("rst_fwd_b",     32'(bus.fwd_b), 0);
        check_eq("rst_halted",    32'(bus.halted), 0);
        check_eq("rst_stall_cnt", 32'(bus.stall_cnt), 0);
        check_eq("rst_flush_cnt", 32'(bus.flush_cnt), 0);
        check_eq("rst_stall",     32'(bus.stall), 0);
        check_eq("rst_bubble",    32'(bus.bubble), 0);
        check_eq("rst_flush",     32'(bus.flush), 0);
        next();
        rst_n = 1'b1;

        // Back-to-back ALU dependency: EX forward.
        id_op(5'd3, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        cycle();
        id_op(5'd4, 1'b0, 5'd3, 1'b1, 5'd0, 1'b0);
        @(negedge clk);
        check_eq("b2b_stall", 32'(bus.stall), 0);
        next();
        id_idle();
        @(negedge clk);
        check_eq("b2b_fwd_a", 32'(bus.fwd_a), 1);
        check_eq("b2b_fwd_b", 32'(bus.fwd_b), 0);
        next();
        @(negedge clk);
        check_eq("bubble_fwd_a", 32'(bus.fwd_a), 0);
        next();
        idle_cycles(3);

        // One unrelated instruction in between: MEM forward.
        id_op(5'd6, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        cycle();
        id_op(5'd7, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        cycle();
        id_op(5'd8, 1'b0, 5'd6, 1'b1, 5'd0, 1'b0);
        @(negedge clk);
        check_eq("gap_stall", 32'(bus.stall), 0);
        next();
        id_idle();
        @(negedge clk);
        check_eq("gap_fwd_a", 32'(bus.fwd_a), 2);
        next();
        idle_cycles(3);

        // Load-use on rb: one stall cycle, then MEM forward.
        id_op(5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
        cycle();
        id_op(5'd10, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1);
        @(negedge clk);
        check_eq("lu_stall",  32'(bus.stall), 1);
        check_eq("lu_bubble", 32'(bus.bubble), 1);
        check_eq("lu_flush",  32'(bus.flush), 0);
        next();
        @(negedge clk);
        check_eq("lu_stall2",  32'(bus.stall), 0);
        check_eq("lu_bubble2", 32'(bus.bubble), 0);
        next();
        id_idle();
        @(negedge clk);
        check_eq("lu_fwd_b",     32'(bus.fwd_b), 2);
        check_eq("lu_fwd_a",     32'(bus.fwd_a), 0);
        check_eq("lu_stall_cnt", 32'(bus.stall_cnt), 1);
        next();
        idle_cycles(3);

        // Register 0 never hazards, load or ALU producer.
        id_op(5'd0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
        cycle();
        id_op(5'd11, 1'b0, 5'd0, 1'b1, 5'd0, 1'b1);
        @(negedge clk);
        check_eq("r0_ld_stall", 32'(bus.stall), 0);
        next();
        id_idle();
        @(negedge clk);
        check_eq("r0_ld_fwd_a", 32'(bus.fwd_a), 0);
        next();
        id_op(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        cycle();
        id_op(5'd12, 1'b0, 5'd0, 1'b1, 5'd0, 1'b0);
        cycle();
        id_idle();
        @(negedge clk);
        check_eq("r0_alu_fwd_a", 32'(bus.fwd_a), 0);
        next();
        idle_cycles(3);

        // Flush beats a simultaneous load-use match.
        id_op(5'd9, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
        cycle();
        id_op(5'd13, 1'b0, 5'd9, 1'b1, 5'd0, 1'b0);
        bus.ex_br_taken = 1'b1;
        @(negedge clk);
        check_eq("fl_flush",  32'(bus.flush), 1);
        check_eq("fl_bubble", 32'(bus.bubble), 1);
        check_eq("fl_stall",  32'(bus.stall), 0);
        next();
        bus.ex_br_taken = 1'b0;
        id_idle();
        @(negedge clk);
        check_eq("fl_flush_cnt", 32'(bus.flush_cnt), 1);
        check_eq("fl_stall_cnt", 32'(bus.stall_cnt), 1);
        check_eq("fl_fwd_a",     32'(bus.fwd_a), 0);
        check_eq("fl_flush_off", 32'(bus.flush), 0);
        next();
        idle_cycles(3);

        // Halt with a full pipeline: three-cycle drain.
        id_op(5'd1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        cycle();
        id_op(5'd2, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        cycle();
        id_op(5'd3, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        cycle();
        id_syscall();
        @(negedge clk);
        check_eq("halt_id_stall", 32'(bus.stall), 0);
        next();
        id_idle();
        n = 0;
        while (!bus.halted && n < 10) begin
            @(negedge clk);
            check_eq("drain_stall", 32'(bus.stall), 1);
            next();
            n++;
        end
        check_eq("drain_len", 32'(n), 3);
        id_op(5'd14, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        @(negedge clk);
        check_eq("halted",        32'(bus.halted), 1);
        check_eq("halted_stall",  32'(bus.stall), 1);
        check_eq("halted_bubble", 32'(bus.bubble), 1);
        check_eq("halt_stall_cnt", 32'(bus.stall_cnt), 1);
        check_eq("halt_flush_cnt", 32'(bus.flush_cnt), 1);
        next();
        @(negedge clk);
        check_eq("halted_hold", 32'(bus.halted), 1);

        // Asynchronous reset while halted.
        rst_n = 1'b0;
        #1;
        check_eq("hrst_halted",    32'(bus.halted), 0);
        check_eq("hrst_stall_cnt", 32'(bus.stall_cnt), 0);
        check_eq("hrst_flush_cnt", 32'(bus.flush_cnt), 0);
        check_eq("hrst_run_stall", 32'(bus.stall), 0);
        next();
        rst_n = 1'b1;

        // Halt with an empty pipeline: one-cycle drain.
        id_syscall();
        @(negedge clk);
        check_eq("halt0_id_stall", 32'(bus.stall), 0);
        next();
        id_idle();
        n = 0;
        while (!bus.halted && n < 10) begin
            cycle();
            n++;
        end
        check_eq("drain0_len", 32'(n), 1);
        rst_n = 1'b0;
        next();
        rst_n = 1'b1;
        idle_cycles(2);

        // Twenty load-use stalls saturate a 4-bit counter.
        for (int i = 0; i < 20; i++) begin
            id_op(5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
            cycle();
            id_op(5'd10, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1);
            cycle();
            cycle();
        end
        id_idle();
        @(negedge clk);
        check_eq("sat_stall_cnt", 32'(bus.stall_cnt), 15);
        check_eq("sat_flush_cnt", 32'(bus.flush_cnt), 0);
        next();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
